// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatch sequencer: source count,
// vector base, source indices, sequencer state encoding and a width helper.
package irq_pkg;

  localparam int NSRC = 5;
  localparam logic [4:0] VEC_BASE = 5'b01000;

  // Source indices; index 0 has the highest priority.
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT1  = 3'd1,
    S_WAIT2  = 3'd2,
    S_PUSH_H = 3'd3,
    S_PUSH_L = 3'd4,
    S_JUMP   = 3'd5
  } irq_state_e;

  // Index width needed to name one of n sources (at least one bit).
  function automatic int idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set
// bit of pend_i and whether any bit was set at all.
module irq_prio_enc #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] pend_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o   = pend_i[i] ? W'(i) : idx_o;
      valid_o = valid_o | pend_i[i];
    end
  end

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Interrupt dispatch sequencer. Tracks IME, the one-instruction EI delay and
// HALT, and at each instruction boundary either lets the next opcode fetch
// proceed or runs the 5 M-cycle dispatch (wait, wait, push PCH, push PCL,
// jump to vector). Optional macro IRQ_HALT_BUG_EN adds the PC_HOLD output
// that models the HALT bug (HALT with IME=0 and an interrupt pending).
module irq_dispatch_ctrl #(
  parameter int         NSRC     = irq_pkg::NSRC,
  parameter logic [4:0] VEC_BASE = irq_pkg::VEC_BASE
) (
  input  logic            CLK,
  input  logic            nRES,
  input  logic            MSTB,
  input  logic            INSTR_END,
  input  logic [NSRC-1:0] IFQ,
  input  logic [NSRC-1:0] IEQ,
  input  logic            EI,
  input  logic            DI,
  input  logic            RETI,
  input  logic            HALT,
  output logic            IRQ_TAKE,
  output logic            PUSH_HI,
  output logic            PUSH_LO,
  output logic            LOAD_VEC,
  output logic [4:0]      VEC,
  output logic [NSRC-1:0] ACK,
  output logic            IME,
  output logic            HALTED
`ifdef IRQ_HALT_BUG_EN
  ,
  output logic            PC_HOLD
`endif
);

  import irq_pkg::*;

  localparam int IW = idx_w(NSRC);

  irq_state_e      state_q, state_d;
  logic            ime_q, ime_d;
  logic            ei_pend_q, ei_pend_d;
  logic            halted_q, halted_d;
  logic [4:0]      vec_q, vec_d;
  logic [IW-1:0]   ack_idx_q, ack_idx_d;
  logic            ack_vld_q, ack_vld_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic            push_hi_q, push_lo_q, load_vec_q;

  logic [NSRC-1:0] pend_s;
  logic            any_s;
  logic            idle_s;
  logic            take_s;
  logic            halt_set_s;
  logic [IW-1:0]   enc_idx_s;
  logic            enc_vld_s;

  assign pend_s = IFQ & IEQ;
  assign any_s  = |pend_s;
  assign idle_s = (state_q == S_IDLE);
  // Dispatch replaces the fetch only at an instruction boundary while awake.
  assign take_s = idle_s & MSTB & INSTR_END & ime_q & any_s & ~halted_q;
  // A pending-but-disabled interrupt at HALT never halts the core.
  assign halt_set_s = idle_s & MSTB & HALT & ~(any_s & ~ime_q);

  irq_prio_enc #(
    .N (NSRC),
    .W (IW)
  ) u_prio_enc (
    .pend_i  (pend_s),
    .idx_o   (enc_idx_s),
    .valid_o (enc_vld_s)
  );

  // Sequencer next state: one step per M-cycle strobe once dispatch starts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = take_s ? S_WAIT1  : S_IDLE;
      S_WAIT1:  state_d = MSTB   ? S_WAIT2  : S_WAIT1;
      S_WAIT2:  state_d = MSTB   ? S_PUSH_H : S_WAIT2;
      S_PUSH_H: state_d = MSTB   ? S_PUSH_L : S_PUSH_H;
      S_PUSH_L: state_d = MSTB   ? S_JUMP   : S_PUSH_L;
      S_JUMP:   state_d = MSTB   ? S_IDLE   : S_JUMP;
      default:  state_d = S_IDLE;
    endcase
  end

  // IME and EI delay: DI beats everything, dispatch entry clears IME,
  // RETI sets it at once, EI takes effect at the end of the next instruction.
  always_comb begin
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    if (MSTB) begin
      if (DI) begin
        ime_d     = 1'b0;
        ei_pend_d = 1'b0;
      end else if (take_s) begin
        ime_d     = 1'b0;
        ei_pend_d = 1'b0;
      end else begin
        if (RETI || (ei_pend_q && INSTR_END)) begin
          ime_d = 1'b1;
        end else begin
          ime_d = ime_q;
        end
        if (EI) begin
          ei_pend_d = 1'b1;
        end else if (INSTR_END) begin
          ei_pend_d = 1'b0;
        end else begin
          ei_pend_d = ei_pend_q;
        end
      end
    end else begin
      ime_d     = ime_q;
      ei_pend_d = ei_pend_q;
    end
  end

  // HALT state: any pending source wakes the core on the very next clock,
  // independent of IME and of the M-cycle strobe.
  always_comb begin
    if (any_s) begin
      halted_d = 1'b0;
    end else if (halt_set_s) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
  end

  // Vector latch on leaving PUSH_H, and the one-clock ACK on entering JUMP.
  // A source that vanished during the push leaves VEC=0 and no ACK.
  always_comb begin
    vec_d     = vec_q;
    ack_idx_d = ack_idx_q;
    ack_vld_d = ack_vld_q;
    ack_d     = '0;
    if ((state_q == S_PUSH_H) && MSTB) begin
      vec_d     = enc_vld_s ? (VEC_BASE + 5'(enc_idx_s)) : 5'b00000;
      ack_idx_d = enc_idx_s;
      ack_vld_d = enc_vld_s;
    end else if ((state_q == S_PUSH_L) && MSTB && ack_vld_q) begin
      ack_d = {{(NSRC-1){1'b0}}, 1'b1} << ack_idx_q;
    end else begin
      ack_d = '0;
    end
  end

  // Sequencer, flag and output registers.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q    <= S_IDLE;
      ime_q      <= 1'b0;
      ei_pend_q  <= 1'b0;
      halted_q   <= 1'b0;
      vec_q      <= 5'b00000;
      ack_idx_q  <= '0;
      ack_vld_q  <= 1'b0;
      ack_q      <= '0;
      push_hi_q  <= 1'b0;
      push_lo_q  <= 1'b0;
      load_vec_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ime_q      <= ime_d;
      ei_pend_q  <= ei_pend_d;
      halted_q   <= halted_d;
      vec_q      <= vec_d;
      ack_idx_q  <= ack_idx_d;
      ack_vld_q  <= ack_vld_d;
      ack_q      <= ack_d;
      push_hi_q  <= (state_d == S_PUSH_H);
      push_lo_q  <= (state_d == S_PUSH_L);
      load_vec_q <= (state_d == S_JUMP);
    end
  end

  assign IRQ_TAKE = take_s;
  assign PUSH_HI  = push_hi_q;
  assign PUSH_LO  = push_lo_q;
  assign LOAD_VEC = load_vec_q;
  assign VEC      = vec_q;
  assign ACK      = ack_q;
  assign IME      = ime_q;
  assign HALTED   = halted_q;

`ifdef IRQ_HALT_BUG_EN
  logic halt_bug_s;
  logic pc_hold_q, pc_hold_d;

  assign halt_bug_s = idle_s & HALT & any_s & ~ime_q;

  // PC_HOLD covers exactly the fetch M-cycle following the buggy HALT.
  always_comb begin
    if (MSTB) begin
      pc_hold_d = halt_bug_s;
    end else begin
      pc_hold_d = pc_hold_q;
    end
  end

  // PC hold register.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      pc_hold_q <= 1'b0;
    end else begin
      pc_hold_q <= pc_hold_d;
    end
  end

  assign PC_HOLD = pc_hold_q;
`endif

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Directed self-checking bench for irq_dispatch_ctrl. Each M-cycle is two
// clocks: MSTB high for one clock, then one idle clock. Inputs change on the
// falling edge; outputs are sampled on the falling edge after the MSTB edge.
module tb_irq_dispatch_ctrl;

  logic       CLK = 1'b0;
  logic       nRES;
  logic       MSTB;
  logic       INSTR_END;
  logic [4:0] IFQ;
  logic [4:0] IEQ;
  logic       EI;
  logic       DI;
  logic       RETI;
  logic       HALT;
  logic       IRQ_TAKE;
  logic       PUSH_HI;
  logic       PUSH_LO;
  logic       LOAD_VEC;
  logic [4:0] VEC;
  logic [4:0] ACK;
  logic       IME;
  logic       HALTED;
`ifdef IRQ_HALT_BUG_EN
  logic       PC_HOLD;
`endif

  int checks = 0;
  int errors = 0;

  irq_dispatch_ctrl dut (
    .CLK       (CLK),
    .nRES      (nRES),
    .MSTB      (MSTB),
    .INSTR_END (INSTR_END),
    .IFQ       (IFQ),
    .IEQ       (IEQ),
    .EI        (EI),
    .DI        (DI),
    .RETI      (RETI),
    .HALT      (HALT),
    .IRQ_TAKE  (IRQ_TAKE),
    .PUSH_HI   (PUSH_HI),
    .PUSH_LO   (PUSH_LO),
    .LOAD_VEC  (LOAD_VEC),
    .VEC       (VEC),
    .ACK       (ACK),
    .IME       (IME),
    .HALTED    (HALTED)
`ifdef IRQ_HALT_BUG_EN
    ,
    .PC_HOLD   (PC_HOLD)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One MSTB clock; returns at the falling edge right after it.
  task automatic mstb_edge();
    MSTB = 1'b1;
    @(negedge CLK);
    MSTB = 1'b0;
  endtask

  task automatic idle_clk();
    @(negedge CLK);
  endtask

  // Boundary MSTB with a check of the combinational IRQ_TAKE before the edge.
  task automatic take_edge(input string tag, input logic exp);
    MSTB = 1'b1;
    #1;
    check(tag, IRQ_TAKE, exp);
    @(negedge CLK);
    MSTB = 1'b0;
  endtask

  // Remaining dispatch steps from WAIT1 back to IDLE; optionally drops IE
  // while in PUSH_H.
  task automatic tail(input string tag, input logic kill_ie,
                      input logic [4:0] exp_vec, input logic [4:0] exp_ack);
    INSTR_END = 1'b0;
    mstb_edge(); check({tag, "_wait2_nopush"}, PUSH_HI, 1'b0); idle_clk();
    mstb_edge(); check({tag, "_push_hi"}, PUSH_HI, 1'b1);
    if (kill_ie) IEQ = 5'b00000;
    idle_clk();
    mstb_edge(); check({tag, "_push_lo"}, PUSH_LO, 1'b1);
    check({tag, "_vec"}, VEC, exp_vec); check({tag, "_ack_early"}, ACK, 5'b00000);
    idle_clk();
    mstb_edge(); check({tag, "_load_vec"}, LOAD_VEC, 1'b1); check({tag, "_ack"}, ACK, exp_ack);
    idle_clk(); check({tag, "_ack_one_clk"}, ACK, 5'b00000); check({tag, "_load_hold"}, LOAD_VEC, 1'b1);
    mstb_edge(); check({tag, "_load_end"}, LOAD_VEC, 1'b0); check({tag, "_ime_clr"}, IME, 1'b0);
    idle_clk();
  endtask

  initial begin
    nRES = 1'b0; MSTB = 1'b0; INSTR_END = 1'b0; IFQ = 5'b00000; IEQ = 5'h1F;
    EI = 1'b0; DI = 1'b0; RETI = 1'b0; HALT = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ime", IME, 1'b0);      check("rst_halted", HALTED, 1'b0);
    check("rst_vec", VEC, 5'b00000);  check("rst_ack", ACK, 5'b00000);
    check("rst_push_hi", PUSH_HI, 1'b0); check("rst_load", LOAD_VEC, 1'b0);
    nRES = 1'b1;
    idle_clk();

    // RETI sets IME on its own strobe.
    RETI = 1'b1; INSTR_END = 1'b1;
    mstb_edge(); check("reti_ime", IME, 1'b1);
    RETI = 1'b0; idle_clk();

    // Dispatch, STAT and Timer pending: STAT wins -> 0x48.
    IFQ = 5'b00110;
    take_edge("take1", 1'b1);
    check("take1_ime_clr", IME, 1'b0); check("take1_wait1", PUSH_HI, 1'b0);
    idle_clk();
    tail("d1", 1'b0, 5'b01001, 5'b00010);
    INSTR_END = 1'b1;
    take_edge("after_d1_no_take", 1'b0);
    IFQ = 5'b00000; idle_clk();

    // EI delay: no dispatch at the EI boundary nor the NOP boundary.
    IFQ = 5'b00001; EI = 1'b1; INSTR_END = 1'b1;
    take_edge("ei_bnd", 1'b0); check("ei_ime0", IME, 1'b0);
    EI = 1'b0; idle_clk();
    take_edge("nop_bnd", 1'b0); check("nop_ime1", IME, 1'b1);
    idle_clk();
    take_edge("ei_take", 1'b1); check("ei_take_ime", IME, 1'b0);
    idle_clk();
    tail("d2", 1'b0, 5'b01000, 5'b00001);
    IFQ = 5'b00000;

    // IE dropped during PUSH_H: VEC=0, no ACK, LOAD_VEC still runs.
    RETI = 1'b1; INSTR_END = 1'b1;
    mstb_edge(); RETI = 1'b0; idle_clk();
    IFQ = 5'b01000;
    take_edge("take3", 1'b1); idle_clk();
    tail("d3", 1'b1, 5'b00000, 5'b00000);
    IEQ = 5'h1F; IFQ = 5'b00000;

    // HALT with IME=0; Timer wakes it without dispatch.
    HALT = 1'b1; INSTR_END = 1'b1;
    mstb_edge(); check("halt_set", HALTED, 1'b1);
    HALT = 1'b0; idle_clk();
    mstb_edge(); check("halt_hold", HALTED, 1'b1); idle_clk();
    IFQ = 5'b00100;
    idle_clk(); check("halt_wake", HALTED, 1'b0);
    take_edge("wake_no_disp", 1'b0); check("wake_ime0", IME, 1'b0);
    INSTR_END = 1'b0; idle_clk();
    mstb_edge(); check("wake_fetch", PUSH_HI, 1'b0); idle_clk();

    // HALT with IME=0 and a pending source never halts.
    HALT = 1'b1; INSTR_END = 1'b1;
    mstb_edge(); check("haltbug_nohalt", HALTED, 1'b0);
`ifdef IRQ_HALT_BUG_EN
    check("pc_hold_set", PC_HOLD, 1'b1);
`endif
    HALT = 1'b0; idle_clk();
    mstb_edge();
`ifdef IRQ_HALT_BUG_EN
    check("pc_hold_clr", PC_HOLD, 1'b0);
`endif
    check("haltbug_still_awake", HALTED, 1'b0);
    idle_clk();
    IFQ = 5'b00000;

    // HALT with IME=1: wake leads straight into dispatch.
    RETI = 1'b1;
    mstb_edge(); RETI = 1'b0; idle_clk();
    HALT = 1'b1;
    mstb_edge(); check("halt2_set", HALTED, 1'b1);
    HALT = 1'b0; idle_clk();
    IFQ = 5'b00010;
    idle_clk(); check("halt2_wake", HALTED, 1'b0);
    take_edge("wake_take", 1'b1); idle_clk();
    tail("d4", 1'b0, 5'b01001, 5'b00010);
    IFQ = 5'b00000;

    // EI and DI together: DI wins, nothing armed.
    EI = 1'b1; DI = 1'b1; INSTR_END = 1'b1;
    mstb_edge(); EI = 1'b0; DI = 1'b0; idle_clk();
    mstb_edge(); check("ei_di_ime", IME, 1'b0); idle_clk();
    // EI then DI cancels the pending enable.
    EI = 1'b1;
    mstb_edge(); EI = 1'b0; idle_clk();
    DI = 1'b1;
    mstb_edge(); check("di_cancel_ime", IME, 1'b0); DI = 1'b0; idle_clk();
    mstb_edge(); check("di_cancel_ime2", IME, 1'b0); idle_clk();
    // DI clears an active IME.
    RETI = 1'b1;
    mstb_edge(); RETI = 1'b0; check("reti2_ime", IME, 1'b1); idle_clk();
    DI = 1'b1;
    mstb_edge(); check("di_clr_ime", IME, 1'b0); DI = 1'b0; idle_clk();

    // Reset during PUSH_L abandons the dispatch with no ACK.
    RETI = 1'b1;
    mstb_edge(); RETI = 1'b0; idle_clk();
    IFQ = 5'b00001;
    take_edge("take5", 1'b1); INSTR_END = 1'b0; idle_clk();
    mstb_edge(); idle_clk();
    mstb_edge(); idle_clk();
    mstb_edge(); check("d5_push_lo", PUSH_LO, 1'b1); idle_clk();
    nRES = 1'b0;
    #1;
    check("rst_mid_push_lo", PUSH_LO, 1'b0); check("rst_mid_ime", IME, 1'b0);
    check("rst_mid_vec", VEC, 5'b00000);     check("rst_mid_ack", ACK, 5'b00000);
    @(negedge CLK);
    nRES = 1'b1;
    idle_clk();
    for (int i = 0; i < 3; i++) begin
      mstb_edge();
      check("post_rst_ack", ACK, 5'b00000);
      check("post_rst_load", LOAD_VEC, 1'b0);
      idle_clk();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
